// File: rtl/axi4_stream_downsizer.sv
// Splits each DATA_IN_SIZE word into RATIO DATA_OUT_SIZE beats, LSB slice first; first beat 1 cycle after accept.
// Backpressure: beats hold while write_data_ready is low; a new word is taken only on the final beat's handshake.
module axi4_stream_downsizer #(
    parameter int DATA_IN_SIZE  = 32,
    parameter int DATA_OUT_SIZE = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [DATA_IN_SIZE-1:0]  read_data,
    input  logic                     read_data_valid,
    output logic                     read_data_ready,
    output logic [DATA_OUT_SIZE-1:0] write_data,
    output logic                     write_data_valid,
    input  logic                     write_data_ready,
    output logic                     write_data_last
);

    localparam int RATIO = DATA_IN_SIZE / DATA_OUT_SIZE;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    generate
        if ((DATA_IN_SIZE % DATA_OUT_SIZE) != 0 || RATIO < 1) begin : g_bad_ratio
            $error("DATA_IN_SIZE must be a positive integer multiple of DATA_OUT_SIZE");
        end
    endgenerate

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_nxt;
    logic [DATA_IN_SIZE-1:0] hold_data;
    logic                    at_last;
    logic                    in_hs;
    logic                    out_hs;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= EMPTY;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_data <= '0;
        end else if (in_hs) begin
            hold_data <= read_data;
        end
    end

    always_comb begin
        at_last          = (idx == LAST_IDX);
        write_data_valid = (state == FULL);
        write_data_last  = (state == FULL) && at_last;
        // Ready on the final beat's handshake lets the next word load with no bubble.
        read_data_ready  = resetn && ((state == EMPTY) ||
                                      ((state == FULL) && at_last && write_data_ready));
        in_hs            = read_data_valid && read_data_ready;
        out_hs           = write_data_valid && write_data_ready;
        state_nxt        = state;
        idx_nxt          = idx;
        case (state)
            EMPTY: begin
                if (in_hs) begin
                    state_nxt = FULL;
                    idx_nxt   = '0;
                end
            end
            FULL: begin
                if (out_hs) begin
                    if (at_last) begin
                        idx_nxt   = '0;
                        state_nxt = in_hs ? FULL : EMPTY;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = EMPTY;
                idx_nxt   = '0;
            end
        endcase
    end

    generate
        if (RATIO == 1) begin : g_pass
            assign write_data = hold_data;
        end else begin : g_slice
            logic [RATIO-1:0][DATA_OUT_SIZE-1:0] slices;
            assign slices     = hold_data;
            assign write_data = slices[idx];
        end
    endgenerate

endmodule

// File: tb/tb_axi4_stream_downsizer.sv
// Bench for axi4_stream_downsizer: queue-based beat model for the 32->8 instance plus a 32->32 instance.
module tb_axi4_stream_downsizer;

    localparam int RATIO = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] rd_dat = '0;
    logic        rd_vld = 1'b0;
    logic        rd_rdy;
    logic [7:0]  wr_dat;
    logic        wr_vld;
    logic        wr_rdy = 1'b1;
    logic        wr_last;

    logic [31:0] r2_dat = '0;
    logic        r2_vld = 1'b0;
    logic        r2_rdy;
    logic [31:0] w2_dat;
    logic        w2_vld;
    logic        w2_rdy = 1'b1;
    logic        w2_last;

    always #5 clk = ~clk;

    axi4_stream_downsizer #(.DATA_IN_SIZE(32), .DATA_OUT_SIZE(8)) dut (
        .clk(clk), .resetn(resetn),
        .read_data(rd_dat), .read_data_valid(rd_vld), .read_data_ready(rd_rdy),
        .write_data(wr_dat), .write_data_valid(wr_vld), .write_data_ready(wr_rdy),
        .write_data_last(wr_last)
    );

    axi4_stream_downsizer #(.DATA_IN_SIZE(32), .DATA_OUT_SIZE(32)) dut2 (
        .clk(clk), .resetn(resetn),
        .read_data(r2_dat), .read_data_valid(r2_vld), .read_data_ready(r2_rdy),
        .write_data(w2_dat), .write_data_valid(w2_vld), .write_data_ready(w2_rdy),
        .write_data_last(w2_last)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: remaining beats of the held word, oldest first.
    logic [7:0]  mq[$];
    logic [7:0]  log_d[$];
    bit          log_l[$];
    bit          log_r[$];
    int          log_c[$];
    logic [31:0] log2[$];

    bit ready_script[$];
    bit rnd_mode = 1'b0;

    always @(negedge resetn) mq.delete();

    always @(posedge clk) begin
        cyc++;
        if (resetn) begin
            automatic bit m_rdy = (mq.size() == 0) || (mq.size() == 1 && wr_rdy);
            automatic bit ihs   = rd_vld && m_rdy;
            automatic bit ohs   = (mq.size() > 0) && wr_rdy;
            if (ohs) void'(mq.pop_front());
            if (ihs) for (int i = 0; i < RATIO; i++) mq.push_back(rd_dat[i*8 +: 8]);
        end
    end

    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_rdy", rd_rdy, 0);
            chk("rst_vld", wr_vld, 0);
            chk("rst_last", wr_last, 0);
            chk("rst_dat", wr_dat, 0);
        end else begin
            chk("rdy", rd_rdy, (mq.size() == 0) || (mq.size() == 1 && wr_rdy));
            chk("vld", wr_vld, mq.size() > 0);
            chk("last", wr_last, mq.size() == 1);
            if (mq.size() > 0) chk("dat", wr_dat, mq[0]);
            if (wr_vld && wr_rdy) begin
                log_d.push_back(wr_dat);
                log_l.push_back(wr_last);
                log_r.push_back(rd_rdy);
                log_c.push_back(cyc);
            end
            chk("r1_last", w2_last, w2_vld);
            if (w2_vld && w2_rdy) log2.push_back(w2_dat);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (ready_script.size() > 0) wr_rdy = ready_script.pop_front();
            else if (rnd_mode) wr_rdy = 1'($urandom_range(0, 1));
            else wr_rdy = 1'b1;
            w2_rdy = 1'($urandom_range(0, 1));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        bit acc = 1'b0;
        rd_dat = w;
        rd_vld = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = rd_rdy;
            @(posedge clk);
            #1;
        end
        rd_vld = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic send2(input logic [31:0] w);
        bit acc = 1'b0;
        r2_dat = w;
        r2_vld = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = r2_rdy;
            @(posedge clk);
            #1;
        end
        r2_vld = 1'b0;
        if (!acc) chk("send2_timeout", 0, 1);
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 400 && log_d.size() < n; i++) @(posedge clk);
        #1;
        if (log_d.size() < n) chk("beat_timeout", log_d.size(), n);
    endtask

    task automatic clear_log();
        log_d.delete(); log_l.delete(); log_r.delete(); log_c.delete();
    endtask

    task automatic chk_seq(input string name, input logic [63:0] exp_words, input int n);
        for (int i = 0; i < n; i++) begin
            if (i < log_d.size()) chk(name, log_d[i], exp_words[i*8 +: 8]);
            else chk(name, 64'hDEAD, exp_words[i*8 +: 8]);
        end
    endtask

    initial begin
        int sent = 0;
        logic [63:0] exp;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        chk("rdy_on_release", rd_rdy, 1);
        @(posedge clk);
        #1;

        // Single word, ready high
        clear_log();
        send_word(32'h44332211);
        wait_beats(4);
        exp = 64'h44332211;
        chk_seq("single", exp, 4);
        for (int i = 0; i < 4 && i < log_l.size(); i++) begin
            chk("single_last", log_l[i], i == 3);
            chk("single_consec", log_c[i] - log_c[0], i);
        end
        idle(3);

        // Two words back-to-back, no bubble
        clear_log();
        send_word(32'h03020100);
        send_word(32'h07060504);
        wait_beats(8);
        exp = 64'h0706050403020100;
        chk_seq("b2b", exp, 8);
        if (log_c.size() >= 8) chk("b2b_span", log_c[7] - log_c[0], 7);
        if (log_r.size() >= 4) begin
            chk("b2b_rdy_on_03", log_r[3], 1);
            chk("b2b_rdy_on_02", log_r[2], 0);
        end
        idle(3);

        // Stall three cycles on the third beat
        clear_log();
        ready_script = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        send_word(32'h44332211);
        wait_beats(4);
        exp = 64'h44332211;
        chk_seq("stall", exp, 4);
        if (log_c.size() >= 4) begin
            chk("stall_gap", log_c[2] - log_c[1], 4);
            chk("stall_rdy_on_33", log_r[2], 0);
        end
        idle(3);

        // Second word offered while the first is on beat 1
        clear_log();
        send_word(32'h44332211);
        idle(1);
        send_word(32'hDDCCBBAA);
        wait_beats(8);
        exp = 64'hDDCCBBAA44332211;
        chk_seq("overlap", exp, 8);
        idle(3);

        // Asynchronous reset mid-word
        clear_log();
        send_word(32'h44332211);
        wait_beats(2);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_vld", wr_vld, 0);
        chk("async_rst_rdy", rd_rdy, 0);
        idle(2);
        resetn = 1'b1;
        clear_log();
        send_word(32'h88776655);
        wait_beats(4);
        exp = 64'h88776655;
        chk_seq("post_rst", exp, 4);
        idle(3);
        chk("post_rst_count", log_d.size(), 4);

        // Randomized words, gaps and backpressure
        clear_log();
        rnd_mode = 1'b1;
        for (int k = 0; k < 40; k++) begin
            send_word($urandom);
            sent++;
            idle($urandom_range(0, 2));
        end
        rnd_mode = 1'b0;
        wait_beats(sent * RATIO);
        idle(2);
        chk("rnd_beats", log_d.size(), sent * RATIO);

        // 32->32 instance: pure register stage
        send2(32'd10);
        send2(32'd11);
        send2(32'd12);
        for (int i = 0; i < 200 && log2.size() < 3; i++) @(posedge clk);
        #1;
        chk("r1_count", log2.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < log2.size()) chk("r1_dat", log2[i], 10 + i);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
